// File: rtl/udp_sweep_controller.sv
// Exhaustive sweep sequencer for a 3-input UDP circuit (e = F(a,b,c), f = e & d).
// Steps {a,b,c} through minterms 0..7, samples e/f after a settle time, and scores against a truth table.
//
// state  | meaning
// IDLE   | waiting for start; circuit inputs held at zero; results held
// SETTLE | {a,b,c} = index, d = latched d_sel; waiting for the circuit to settle
// SAMPLE | capture e/f for the current minterm and score it
// DONE   | one-cycle done pulse; pass reflects the final mismatch count

module udp_sweep_controller #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clock,
  input  logic       reset_b,
  input  logic       start,
  input  logic       d_sel,
  input  logic [7:0] expected_e,
  input  logic       e_in,
  input  logic       f_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       busy,
  output logic       done,
  output logic [7:0] e_map,
  output logic [7:0] f_map,
  output logic [3:0] mismatch_cnt,
  output logic       pass
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Settle timer counts down from SETTLE_CYCLES-1; terminal count is zero.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_next;
  logic [2:0] idx;
  logic [3:0] cnt;
  logic       d_lat;
  logic [7:0] exp_lat;
  logic       active;
  logic       exp_e_bit;
  logic       exp_f_bit;
  logic       miss;
  logic [3:0] mismatch_next;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SETTLE;
      SETTLE:  if (cnt == 4'd0) state_next = SAMPLE;
      SAMPLE:  state_next = (idx == 3'd7) ? DONE : SETTLE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    active        = (state == SETTLE) || (state == SAMPLE);
    a             = active & idx[2];
    b             = active & idx[1];
    c             = active & idx[0];
    d             = active & d_lat;
    busy          = active;
    done          = (state == DONE);
    exp_e_bit     = exp_lat[idx];
    exp_f_bit     = exp_e_bit & d_lat;
    miss          = (e_in != exp_e_bit) || (f_in != exp_f_bit);
    mismatch_next = mismatch_cnt + {3'b000, miss};
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state        <= IDLE;
      idx          <= 3'd0;
      cnt          <= 4'd0;
      d_lat        <= 1'b0;
      exp_lat      <= 8'h00;
      e_map        <= 8'h00;
      f_map        <= 8'h00;
      mismatch_cnt <= 4'd0;
      pass         <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            d_lat        <= d_sel;
            exp_lat      <= expected_e;
            e_map        <= 8'h00;
            f_map        <= 8'h00;
            mismatch_cnt <= 4'd0;
            pass         <= 1'b0;
            idx          <= 3'd0;
            cnt          <= SETTLE_LOAD;
          end
        end
        SETTLE: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        SAMPLE: begin
          e_map[idx]   <= e_in;
          f_map[idx]   <= f_in;
          mismatch_cnt <= mismatch_next;
          cnt          <= SETTLE_LOAD;
          // pass is resolved here so it already includes minterm 7 while done is high
          if (idx == 3'd7) pass <= (mismatch_next == 4'd0);
          else             idx  <= idx + 3'd1;
        end
        DONE: begin
          idx <= 3'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_sweep_controller.sv
// Scoreboard bench for udp_sweep_controller: two instances (settle 1 and 3) driving a behavioural UDP circuit.
// Expected sweep results come from a minterm-by-minterm reference model pushed at start time.

module tb_udp_sweep_controller;

  logic clock = 1'b0;
  logic reset_b = 1'b0;
  always #5 clock = ~clock;

  logic       start1 = 1'b0, dsel1 = 1'b0;
  logic [7:0] exp1 = 8'h00;
  logic       e1, f1, a1, b1, c1, d1, busy1, done1, pass1;
  logic [7:0] emap1, fmap1;
  logic [3:0] mm1;

  logic       start3 = 1'b0, dsel3 = 1'b0;
  logic [7:0] exp3 = 8'h00;
  logic       e3, f3, a3, b3, c3, d3, busy3, done3, pass3;
  logic [7:0] emap3, fmap3;
  logic [3:0] mm3;

  logic [7:0] circ_tbl = 8'hE3;
  logic       circ_stuck = 1'b0;

  assign e1 = circ_stuck ? 1'b0 : circ_tbl[{a1, b1, c1}];
  assign f1 = e1 & d1;
  assign e3 = circ_stuck ? 1'b0 : circ_tbl[{a3, b3, c3}];
  assign f3 = e3 & d3;

  udp_sweep_controller #(.SETTLE_CYCLES(1)) dut1 (
    .clock(clock), .reset_b(reset_b), .start(start1), .d_sel(dsel1), .expected_e(exp1),
    .e_in(e1), .f_in(f1), .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
    .e_map(emap1), .f_map(fmap1), .mismatch_cnt(mm1), .pass(pass1));

  udp_sweep_controller #(.SETTLE_CYCLES(3)) dut3 (
    .clock(clock), .reset_b(reset_b), .start(start3), .d_sel(dsel3), .expected_e(exp3),
    .e_in(e3), .f_in(f3), .a(a3), .b(b3), .c(c3), .d(d3), .busy(busy3), .done(done3),
    .e_map(emap3), .f_map(fmap3), .mismatch_cnt(mm3), .pass(pass3));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] em;
    logic [7:0] fm;
    logic [3:0] mm;
    logic       ps;
    int         done_cyc;
  } exp_t;

  exp_t sb1[$];
  exp_t sb3[$];
  exp_t x1, x3;
  int   act_start1 = -1, act_start3 = -1;
  logic act_d1 = 1'b0, act_d3 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, expv);
    end
  endtask

  // Reference: evaluate the circuit at every minterm, score each one once.
  function automatic exp_t model(input logic [7:0] tbl, input logic stuck, input logic dsel,
                                 input logic [7:0] expv, input int settle, input int scyc);
    exp_t r;
    logic e, f;
    r.em = 8'h00;
    r.fm = 8'h00;
    r.mm = 4'd0;
    for (int m = 0; m < 8; m++) begin
      e = stuck ? 1'b0 : tbl[m];
      f = e & dsel;
      r.em[m] = e;
      r.fm[m] = f;
      if (e != expv[m] || f != (expv[m] & dsel)) r.mm = r.mm + 4'd1;
    end
    r.ps = (r.mm == 4'd0);
    r.done_cyc = scyc + 8 * (settle + 1);
    return r;
  endfunction

  always @(negedge clock) begin
    if (done1) begin
      chk("done1_pending", 32'(sb1.size() != 0), 32'd1);
      if (sb1.size() != 0) begin
        x1 = sb1.pop_front();
        chk("done1_cycle", 32'(cyc), 32'(x1.done_cyc));
        chk("e_map1", 32'(emap1), 32'(x1.em));
        chk("f_map1", 32'(fmap1), 32'(x1.fm));
        chk("mismatch_cnt1", 32'(mm1), 32'(x1.mm));
        chk("pass1", 32'(pass1), 32'(x1.ps));
        act_start1 = -1;
      end
    end
    if (busy1 && act_start1 >= 0) begin
      chk("abc1", 32'({a1, b1, c1}), 32'((cyc - act_start1) / 2));
      chk("d1", 32'(d1), 32'(act_d1));
    end
    if (done3) begin
      chk("done3_pending", 32'(sb3.size() != 0), 32'd1);
      if (sb3.size() != 0) begin
        x3 = sb3.pop_front();
        chk("done3_cycle", 32'(cyc), 32'(x3.done_cyc));
        chk("e_map3", 32'(emap3), 32'(x3.em));
        chk("f_map3", 32'(fmap3), 32'(x3.fm));
        chk("mismatch_cnt3", 32'(mm3), 32'(x3.mm));
        chk("pass3", 32'(pass3), 32'(x3.ps));
        act_start3 = -1;
      end
    end
    if (busy3 && act_start3 >= 0) begin
      chk("abc3", 32'({a3, b3, c3}), 32'((cyc - act_start3) / 4));
      chk("d3", 32'(d3), 32'(act_d3));
    end
  end

  function automatic logic busy_of(input int inst);
    return (inst == 1) ? busy1 : busy3;
  endfunction

  task automatic issue(input int inst, input logic dsel, input logic [7:0] expv);
    @(negedge clock);
    if (inst == 1) begin start1 = 1'b1; dsel1 = dsel; exp1 = expv; end
    else           begin start3 = 1'b1; dsel3 = dsel; exp3 = expv; end
    @(posedge clock);
    #1;
    if (inst == 1) begin
      act_start1 = cyc; act_d1 = dsel;
      sb1.push_back(model(circ_tbl, circ_stuck, dsel, expv, 1, cyc));
    end else begin
      act_start3 = cyc; act_d3 = dsel;
      sb3.push_back(model(circ_tbl, circ_stuck, dsel, expv, 3, cyc));
    end
    @(negedge clock);
    // scramble the configuration inputs; the sweep must run on the latched copies
    if (inst == 1) begin start1 = 1'b0; dsel1 = ~dsel; exp1 = ~expv; end
    else           begin start3 = 1'b0; dsel3 = ~dsel; exp3 = ~expv; end
  endtask

  task automatic sweep(input int inst, input logic dsel, input logic [7:0] expv, input bit mid);
    int n;
    issue(inst, dsel, expv);
    if (mid) begin
      repeat (4) @(negedge clock);
      if (inst == 1) begin start1 = 1'b1; exp1 = 8'h00; dsel1 = 1'b0; end
      else           begin start3 = 1'b1; exp3 = 8'h00; dsel3 = 1'b0; end
      @(negedge clock);
      if (inst == 1) start1 = 1'b0; else start3 = 1'b0;
    end
    n = 0;
    while (busy_of(inst) && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("sweep_timeout", 32'(n < 100), 32'd1);
    if (mid) begin
      if (inst == 1) start1 = 1'b1; else start3 = 1'b1;
      @(posedge clock);
      #1;
      if (inst == 1) start1 = 1'b0; else start3 = 1'b0;
      @(negedge clock);
      chk("start_in_done_ignored", 32'(busy_of(inst)), 32'd0);
    end
  endtask

  task automatic chk_result1(input string tag, input logic [7:0] em, input logic [7:0] fm,
                             input logic [3:0] mm, input logic ps);
    chk({tag, "_e_map"}, 32'(emap1), 32'(em));
    chk({tag, "_f_map"}, 32'(fmap1), 32'(fm));
    chk({tag, "_mismatch"}, 32'(mm1), 32'(mm));
    chk({tag, "_pass"}, 32'(pass1), 32'(ps));
    chk({tag, "_done"}, 32'(done1), 32'd1);
  endtask

  task automatic chk_zero1(input string tag);
    chk({tag, "_ctl1"}, 32'({a1, b1, c1, d1, busy1, done1, pass1}), 32'd0);
    chk({tag, "_maps1"}, 32'({emap1, fmap1, mm1}), 32'd0);
  endtask

  initial begin
    int n;
    int inst;
    logic [7:0] ev;
    logic dv;

    #12;
    chk_zero1("reset");
    chk("reset_ctl3", 32'({a3, b3, c3, d3, busy3, done3, pass3}), 32'd0);
    chk("reset_maps3", 32'({emap3, fmap3, mm3}), 32'd0);
    @(negedge clock);
    reset_b = 1'b1;

    // correct circuit, d=1 then d=0
    sweep(1, 1'b1, 8'hE3, 1'b0);
    chk_result1("s1", 8'hE3, 8'hE3, 4'd0, 1'b1);
    sweep(1, 1'b0, 8'hE3, 1'b0);
    chk_result1("s2", 8'hE3, 8'h00, 4'd0, 1'b1);

    // e stuck at 0
    circ_stuck = 1'b1;
    sweep(1, 1'b1, 8'hE3, 1'b0);
    chk_result1("s3", 8'h00, 8'h00, 4'd5, 1'b0);
    circ_stuck = 1'b0;

    // longer settle
    sweep(3, 1'b1, 8'hE3, 1'b0);
    chk("s4_e_map3", 32'(emap3), 32'hE3);
    chk("s4_pass3", 32'(pass3), 32'd1);

    // mid-sweep restart and config change are ignored
    sweep(1, 1'b1, 8'hE3, 1'b1);
    repeat (2) @(negedge clock);
    chk("s5_e_map_held", 32'(emap1), 32'hE3);
    chk("s5_pass_held", 32'(pass1), 32'd1);

    // reset in minterm 4
    issue(1, 1'b1, 8'hE3);
    n = 0;
    while ({a1, b1, c1} != 3'd4 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("s6_reach_m4", 32'(n < 100), 32'd1);
    #2;
    reset_b = 1'b0;
    sb1.delete();
    act_start1 = -1;
    #1;
    chk_zero1("s6_abort");
    repeat (3) @(negedge clock);
    chk_zero1("s6_held");
    reset_b = 1'b1;
    repeat (20) @(negedge clock);
    chk("s6_no_done_busy", 32'({busy1, done1}), 32'd0);
    sweep(1, 1'b1, 8'hE3, 1'b0);
    chk_result1("s6_after", 8'hE3, 8'hE3, 4'd0, 1'b1);

    // randomized sweeps
    for (int i = 0; i < 24; i++) begin
      circ_tbl = 8'($urandom);
      circ_stuck = ($urandom_range(0, 3) == 0);
      ev = ($urandom_range(0, 1) == 1) ? circ_tbl : 8'($urandom);
      dv = 1'($urandom_range(0, 1));
      inst = (i % 3 == 0) ? 3 : 1;
      sweep(inst, dv, ev, ($urandom_range(0, 4) == 0));
    end

    repeat (4) @(negedge clock);
    chk("sb1_drained", 32'(sb1.size()), 32'd0);
    chk("sb3_drained", 32'(sb3.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/udp_sweep_controller.md
Name: udp_sweep_controller

Overview:
- Sequencer that exhaustively exercises a 3-input user-defined-primitive circuit (e = F(a,b,c), f = e & d).
- Steps {a,b,c} through minterms 0..7 with a programmable settle time and samples e and f for each minterm.
- Builds 8-bit minterm maps of e and f, checks them against an expected truth table, and reports pass/fail and the mismatch count.
- Sits between a test/config host and the combinational UDP circuit. It drives the circuit's inputs and reads its outputs.

Parameters:
SETTLE_CYCLES, 1, clock cycles the inputs are held before sampling; legal range 1..15

Ports:
clock  input  1  system clock, rising-edge
reset_b  input  1  asynchronous active-low reset
start  input  1  begin a sweep; sampled only in IDLE
d_sel  input  1  value driven on d for the whole sweep; latched at start
expected_e  input  8  expected truth table of e, bit i = F(minterm i), i = {a,b,c}; latched at start
e_in  input  1  e output of the UDP circuit
f_in  input  1  f output of the UDP circuit
a  output  1  circuit input a (MSB of minterm index)
b  output  1  circuit input b
c  output  1  circuit input c (LSB)
d  output  1  circuit input d
busy  output  1  high while a sweep is in progress
done  output  1  one-cycle pulse at the end of a sweep
e_map  output  8  captured e per minterm
f_map  output  8  captured f per minterm
mismatch_cnt  output  4  number of minterms (0..8) where e or f differs from expected
pass  output  1  sweep result; valid from done until the next start

Behaviour:
- Reset (reset_b low, asynchronous):
  - state=IDLE; a=b=c=d=0; busy=0; done=0.
  - e_map=0, f_map=0, mismatch_cnt=0, pass=0.
  - Internal index and settle counter cleared.
  - A reset during a sweep aborts it; no done pulse is produced.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - a=b=c=0; d=0.
  - On start=1 at a rising edge:
    - latch d_sel and expected_e;
    - clear e_map, f_map, mismatch_cnt and pass;
    - set index=0, cnt=0;
    - go to SETTLE.
- SETTLE:
  - {a,b,c}=index; d=latched d_sel; busy=1.
  - If cnt==SETTLE_CYCLES-1, go to SAMPLE; otherwise cnt++.
- SAMPLE:
  - Inputs unchanged; busy=1.
  - On the edge leaving SAMPLE:
    - e_map[index] <= e_in; f_map[index] <= f_in;
    - exp_f = expected_e[index] & d_sel;
    - if (e_in != expected_e[index]) or (f_in != exp_f), then mismatch_cnt++ (at most once per minterm).
  - If index==7, go to DONE; otherwise index++, cnt=0, go to SETTLE.
- DONE:
  - busy=0; done=1 for exactly one cycle; a=b=c=d=0.
  - pass=1 if mismatch_cnt==0, computed from the final count including minterm 7.
  - Go to IDLE.
- Timing:
  - Each minterm takes SETTLE_CYCLES+1 cycles.
  - DONE is entered on the 8*(SETTLE_CYCLES+1)-th rising edge after the edge that sampled start. For SETTLE_CYCLES=1 this is the 16th edge.
- start while busy, or during DONE: ignored; no restart, no effect on the latched values.
- Changes to d_sel or expected_e mid-sweep: no effect on the sweep.
- e_map, f_map, mismatch_cnt and pass hold their values in IDLE until the next accepted start.
- Index wrap: index never exceeds 7; the sweep always ends after minterm 7.
- e_in and f_in are assumed to be combinational from a,b,c,d. Nothing is sampled outside SAMPLE.

Test Plan:
1. Correct circuit, F minterms {0,1,5,6,7}: expected_e=8'hE3, d_sel=1, SETTLE_CYCLES=1, pulse start. Required: e_map=8'hE3, f_map=8'hE3, mismatch_cnt=0, pass=1, done on the 16th edge after start.
2. Same circuit with d_sel=0. Required: e_map=8'hE3, f_map=8'h00, mismatch_cnt=0, pass=1.
3. Faulty circuit with e stuck at 0, expected_e=8'hE3, d_sel=1. Required: e_map=8'h00, f_map=8'h00, mismatch_cnt=5, pass=0.
4. SETTLE_CYCLES=3. Required: {a,b,c} holds each index for 4 cycles in order 0..7; done on the 32nd edge after start.
5. Start re-pulsed and expected_e changed to 8'h00 mid-sweep. Required: ignored; result identical to scenario 1; exactly one done pulse.
6. reset_b low at minterm 4. Required: immediate return to all-zero outputs with no done pulse; a new start then completes a normal sweep.
